cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
- Sequences one inference of the CNN core per `start` request.
- Fetches a frame from the synchronous pixel frame buffer in raster order, address 0 first, and streams it into the CNN `in_val`/`data_in` port, honouring backpressure.
- Waits for the `out_val` strobe with a timeout, captures `decision`, and reports completion.
- Sits between the frame-buffer/host logic and the CNN core.

Parameters:
- IMG_PIXELS, 784, pixels per frame (28x28).
- DATA_BITS, 8, pixel width.
- ADDR_BITS, 10, frame-buffer address width; must satisfy 2^ADDR_BITS >= IMG_PIXELS.
- CLASS_BITS, 4, CNN decision width.
- TIMEOUT, 4096, maximum cycles in WAIT_RESULT before abandoning the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE from any non-IDLE state.
- busy  out  1  high in STREAM and WAIT_RESULT.
- done  out  1  one-cycle pulse when a frame finishes, whether by result or by timeout.
- timeout_err  out  1  high together with `done` when the frame ended by timeout; holds until the next accepted start.
- mem_rd_en  out  1  frame-buffer read strobe.
- mem_addr  out  ADDR_BITS  frame-buffer read address.
- mem_rd_data  in  DATA_BITS  read data, valid exactly 1 cycle after mem_rd_en.
- cnn_in_val  out  1  pixel valid to the CNN.
- cnn_data_in  out  DATA_BITS  pixel to the CNN.
- cnn_ready  in  1  CNN accepts a pixel when cnn_in_val && cnn_ready; tie high if the core never stalls.
- cnn_out_val  in  1  CNN result strobe.
- cnn_decision  in  CLASS_BITS  CNN result.
- decision  out  CLASS_BITS  last captured result.
- frame_count  out  16  count of frames completed with a valid result.

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE.
- Pixel buffer empty, counters 0.

FSM states: IDLE, STREAM, WAIT_RESULT, DONE.
- IDLE: on start=1, go to STREAM; clear rd_ptr, sent_cnt and timeout_err.
- STREAM: issue reads and forward pixels. When the IMG_PIXELS-th pixel handshake completes, go to WAIT_RESULT with the wait counter at 0.
- WAIT_RESULT:
  - cnn_out_val=1: decision <= cnn_decision, frame_count += 1 (wraps at 2^16), go to DONE.
  - Otherwise the wait counter increments. At count TIMEOUT-1 without out_val: timeout_err <= 1, decision unchanged, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is not accepted in DONE.

Read pipeline:
- 2-entry pixel FIFO feeds cnn_in_val/cnn_data_in; cnn_in_val = FIFO not empty.
- A read is issued in a cycle when all of the following hold:
  - state is STREAM
  - rd_ptr < IMG_PIXELS
  - (occupancy + outstanding − pop_this_cycle) < 2
- Issuing a read increments rd_ptr. At most one read is outstanding.
- Returned data is pushed into the FIFO the cycle it arrives. Overflow is impossible by construction.
- With cnn_ready held high:
  - First cnn_in_val is 2 cycles after the start-accepting edge.
  - Pixels then arrive on IMG_PIXELS consecutive cycles, addresses 0..IMG_PIXELS-1 in order.
- cnn_data_in is stable while cnn_in_val && !cnn_ready. No pixel is dropped or duplicated.

Boundary conditions:
- start while busy or in DONE is ignored.
- cnn_out_val outside WAIT_RESULT is ignored.
- abort in STREAM/WAIT_RESULT/DONE:
  - Next state is IDLE; FIFO is flushed and any in-flight read data discarded.
  - cnn_in_val is low the cycle after the abort edge.
  - No done pulse; decision and frame_count unchanged.
- abort and cnn_out_val in the same WAIT_RESULT cycle: abort wins.
- start and abort both high in IDLE: start wins.
- rst mid-operation: immediate return to reset values, with no trailing mem_rd_en or cnn_in_val.
- The timeout cycle and cnn_out_val in the same cycle: the result wins.

Test Plan:
- Frame buffer loaded with pixel[i]=i mod 256, cnn_ready=1, CNN model returns out_val 40 cycles after the last pixel with decision=3 -> 784 contiguous beats carrying 0,1,...,255,0,... in order; first beat 2 cycles after start; done pulses once; decision=3; frame_count=1; timeout_err=0.
- Same frame with cnn_ready randomly low 50% of cycles -> exactly 784 accepted beats, correct order, data stable during stalls, mem_rd_en never issued with 2 entries committed.
- TIMEOUT=64 and the CNN never asserts out_val -> done plus timeout_err exactly 64 cycles after entering WAIT_RESULT; decision keeps its prior value (3); frame_count unchanged.
- start pulsed again at pixel 100 of a running frame, and stray out_val injected during STREAM -> both ignored; a single frame of 784 beats completes normally.
- abort at the 300th accepted pixel -> cnn_in_val low the next cycle, no done, busy drops; a following start streams from address 0 for the full 784 beats.
- rst asserted asynchronously mid-stream, between clock edges -> all outputs 0 immediately; after release with start, a clean 784-beat frame completes; frame_count=1.

Source files
------------

// File: rtl/cnn_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, its frame buffer / host logic and
// the CNN core.
//   master : sequencer view (drives status, frame-buffer reads, CNN pixel stream)
//   slave  : environment view (host control, frame-buffer data, CNN result)
// Signals:
//   start, abort          host control levels
//   busy, done,
//   timeout_err           sequencer status
//   mem_rd_en, mem_addr   frame-buffer read request
//   mem_rd_data           frame-buffer data, valid one cycle after mem_rd_en
//   cnn_in_val,
//   cnn_data_in,
//   cnn_ready             pixel stream to the CNN with backpressure
//   cnn_out_val,
//   cnn_decision          CNN result strobe and class
//   decision, frame_count captured result and completed-frame counter
interface cnn_frame_sequencer_if #(
  parameter int DATA_BITS  = 8,
  parameter int ADDR_BITS  = 10,
  parameter int CLASS_BITS = 4
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  logic                  mem_rd_en;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_BITS-1:0]  mem_rd_data;
  logic                  cnn_in_val;
  logic [DATA_BITS-1:0]  cnn_data_in;
  logic                  cnn_ready;
  logic                  cnn_out_val;
  logic [CLASS_BITS-1:0] cnn_decision;
  logic [CLASS_BITS-1:0] decision;
  logic [15:0]           frame_count;

  modport master (
    input  start, abort, mem_rd_data, cnn_ready, cnn_out_val, cnn_decision,
    output busy, done, timeout_err, mem_rd_en, mem_addr, cnn_in_val,
           cnn_data_in, decision, frame_count
  );

  modport slave (
    output start, abort, mem_rd_data, cnn_ready, cnn_out_val, cnn_decision,
    input  busy, done, timeout_err, mem_rd_en, mem_addr, cnn_in_val,
           cnn_data_in, decision, frame_count
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Sequences one CNN inference per start request: streams a frame from the
// synchronous frame buffer (raster order, address 0 first) into the CNN with
// backpressure, waits for the result strobe with a timeout, captures the
// decision and pulses done.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cnn_frame_sequencer_if.master (host control/status, frame-buffer
//        read port, CNN pixel stream and result)
module cnn_frame_sequencer #(
  parameter int IMG_PIXELS = 784,
  parameter int DATA_BITS  = 8,
  parameter int ADDR_BITS  = 10,
  parameter int CLASS_BITS = 4,
  parameter int TIMEOUT    = 4096
) (
  input logic                   clk,
  input logic                   rst,
  cnn_frame_sequencer_if.master bus
);

  // One extra bit so the pointer can hold IMG_PIXELS even when it equals 2^ADDR_BITS.
  localparam int CNT_BITS  = ADDR_BITS + 1;
  localparam int WAIT_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_BITS-1:0]  PIX_TOTAL = CNT_BITS'(IMG_PIXELS);
  localparam logic [CNT_BITS-1:0]  PIX_LAST  = CNT_BITS'(IMG_PIXELS - 1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_RESULT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CNT_BITS-1:0]    rd_ptr;
  logic [CNT_BITS-1:0]    sent_cnt;
  logic [WAIT_BITS-1:0]   wait_cnt;
  logic                   timeout_err_q;
  logic [CLASS_BITS-1:0]  decision_q;
  logic [15:0]            frame_count_q;

  // Two-entry pixel FIFO; rd_pend marks the read whose data arrives this cycle.
  logic [DATA_BITS-1:0]   fifo_q [2];
  logic                   head;
  logic [1:0]             occ;
  logic                   rd_pend;

  logic                   pop;
  logic                   issue;
  logic                   flush;
  logic [2:0]             committed;

  always_comb begin
    pop       = (occ != 2'd0) && bus.cnn_ready;
    committed = 3'(occ) + 3'(rd_pend);
    flush     = bus.abort && (state != S_IDLE);
    // A slot freed by this cycle's pop may be re-committed to a new read.
    issue     = (state == S_STREAM) && !bus.abort && (rd_ptr < PIX_TOTAL) &&
                (committed < (3'd2 + 3'(pop)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head      <= 1'b0;
      occ       <= '0;
      rd_pend   <= 1'b0;
    end else if (flush) begin
      head    <= 1'b0;
      occ     <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      // Write slot is head+occ (mod 2); a push can never meet a full FIFO.
      if (rd_pend) begin
        fifo_q[head ^ occ[0]] <= bus.mem_rd_data;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ + 2'(rd_pend) - 2'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      sent_cnt      <= '0;
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
      decision_q    <= '0;
      frame_count_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_STREAM;
            rd_ptr        <= '0;
            sent_cnt      <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        S_STREAM: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            if (issue) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) begin
              sent_cnt <= sent_cnt + 1'b1;
              if (sent_cnt == PIX_LAST) begin
                state    <= S_WAIT_RESULT;
                wait_cnt <= '0;
              end
            end
          end
        end
        S_WAIT_RESULT: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else if (bus.cnn_out_val) begin
            decision_q    <= bus.cnn_decision;
            frame_count_q <= frame_count_q + 16'd1;
            state         <= S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err_q <= 1'b1;
            state         <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state == S_STREAM) || (state == S_WAIT_RESULT);
  assign bus.done        = (state == S_DONE) && !bus.abort;
  assign bus.timeout_err = timeout_err_q;
  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = rd_ptr[ADDR_BITS-1:0];
  assign bus.cnn_in_val  = (occ != 2'd0);
  assign bus.cnn_data_in = fifo_q[head];
  assign bus.decision    = decision_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: frame-buffer and CNN models,
// a stream monitor holding the expected pixel order, and one task per
// scenario (reset, nominal frame, stalls, timeout, ignored inputs, abort,
// asynchronous reset).
module tb_cnn_frame_sequencer;
  localparam int IMG = 784;
  localparam int DB  = 8;
  localparam int AB  = 10;
  localparam int CB  = 4;
  localparam int TO  = 64;

  logic clk;
  logic rst;

  cnn_frame_sequencer_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .CLASS_BITS(CB)) bus ();

  cnn_frame_sequencer #(
    .IMG_PIXELS(IMG), .DATA_BITS(DB), .ADDR_BITS(AB), .CLASS_BITS(CB), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  logic [DB-1:0] fb [IMG];
  int frame_gen;
  bit stall_mode;

  // monitor state
  int fbeat;
  int rd_exp;
  int done_total;
  int cyc;
  int first_cyc;
  int last_cyc;

  // reference model of captured results
  int            exp_fc;
  logic [CB-1:0] exp_dec;
  logic          exp_to;

  task automatic mem_loop();
    logic          en;
    logic [AB-1:0] a;
    forever begin
      @(negedge clk);
      en = bus.mem_rd_en;
      a  = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_rd_data = (en === 1'b1 && int'(a) < IMG) ? fb[a] : DB'($urandom);
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      bus.cnn_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic monitor_loop();
    int            gen_seen;
    int            pop;
    logic          prev_stall;
    logic [DB-1:0] prev_data;
    gen_seen   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_gen != gen_seen) begin
        gen_seen   = frame_gen;
        fbeat      = 0;
        rd_exp     = 0;
        prev_stall = 1'b0;
      end
      if (rst === 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          vectors++;
          if (bus.cnn_in_val !== 1'b1 || bus.cnn_data_in !== prev_data) begin
            miscompares++;
            $display("FAIL stall_hold: in_val=%b data=%0d, required in_val=1 data=%0d",
                     bus.cnn_in_val, bus.cnn_data_in, prev_data);
          end
        end
        pop = (bus.cnn_in_val === 1'b1 && bus.cnn_ready === 1'b1) ? 1 : 0;
        if (bus.mem_rd_en === 1'b1) begin
          vectors++;
          if (bus.mem_addr !== AB'(rd_exp) || rd_exp >= IMG || (rd_exp - fbeat - pop) >= 2) begin
            miscompares++;
            $display("FAIL rd_issue: addr=%0d committed=%0d, required addr=%0d committed<2 below %0d",
                     bus.mem_addr, rd_exp - fbeat - pop, rd_exp, IMG);
          end
          rd_exp++;
        end
        if (pop == 1) begin
          vectors++;
          if (fbeat >= IMG) begin
            miscompares++;
            $display("FAIL extra_beat: beat %0d, required at most %0d beats", fbeat + 1, IMG);
          end else if (bus.cnn_data_in !== fb[fbeat]) begin
            miscompares++;
            $display("FAIL beat_data: beat %0d data=%0d, required %0d",
                     fbeat, bus.cnn_data_in, fb[fbeat]);
          end
          if (fbeat == 0) first_cyc = cyc;
          last_cyc = cyc;
          fbeat++;
        end
        if (bus.done === 1'b1) done_total++;
        prev_stall = (bus.cnn_in_val === 1'b1) && (bus.cnn_ready !== 1'b1) && (bus.abort !== 1'b1);
        prev_data  = bus.cnn_data_in;
      end
    end
  endtask

  task automatic fill_frame(input bit ramp);
    for (int i = 0; i < IMG; i++) fb[i] = ramp ? DB'(i % 256) : DB'($urandom);
  endtask

  task automatic start_frame(input bit with_abort);
    int lat;
    lat = -1;
    frame_gen++;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = with_abort;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.cnn_in_val === 1'b1) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL first_beat_latency: %0d cycles after start edge, required 2", lat);
    end
  endtask

  // Returns on the rising edge at which the n-th beat of the frame completes.
  task automatic wait_beats(input int n);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (fbeat >= n) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_beats: only %0d beats seen, required %0d", fbeat, n);
  endtask

  task automatic finish_result(input bit respond, input int delay, input logic [CB-1:0] dec);
    int done_k;
    int d0;
    done_k = -1;
    d0     = done_total;
    if (respond) begin
      exp_dec = dec;
      exp_fc  = (exp_fc + 1) % 65536;
      exp_to  = 1'b0;
    end else begin
      exp_to  = 1'b1;
    end
    #1;
    for (int k = 0; k < 150; k++) begin
      bus.cnn_out_val  = respond && (k == delay);
      bus.cnn_decision = (respond && k == delay) ? dec : CB'($urandom);
      @(negedge clk);
      if (bus.done === 1'b1 && done_k < 0) begin
        done_k = k;
        vectors++;
        if (bus.timeout_err !== exp_to || bus.decision !== exp_dec ||
            bus.frame_count !== 16'(exp_fc) || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL done_state: to=%b dec=%0d fc=%0d busy=%b, required to=%b dec=%0d fc=%0d busy=0",
                   bus.timeout_err, bus.decision, bus.frame_count, bus.busy, exp_to, exp_dec, exp_fc);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cnn_out_val = 1'b0;
    vectors++;
    if (done_k != (respond ? delay + 1 : TO)) begin
      miscompares++;
      $display("FAIL done_latency: done %0d cycles after last beat, required %0d",
               done_k, respond ? delay + 1 : TO);
    end
    vectors++;
    if (done_total - d0 != 1) begin
      miscompares++;
      $display("FAIL done_count: %0d pulses, required 1", done_total - d0);
    end
    vectors++;
    if (fbeat != IMG) begin
      miscompares++;
      $display("FAIL beat_count: %0d beats, required %0d", fbeat, IMG);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.cnn_in_val !== 1'b0 || bus.timeout_err !== exp_to) begin
      miscompares++;
      $display("FAIL idle_after: busy=%b in_val=%b to=%b, required 0 0 %b",
               bus.busy, bus.cnn_in_val, bus.timeout_err, exp_to);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.timeout_err, bus.mem_rd_en, bus.mem_addr, bus.cnn_in_val,
         bus.cnn_data_in, bus.decision, bus.frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b to=%b rd_en=%b addr=%0d in_val=%b data=%0d dec=%0d fc=%0d, required all 0",
               bus.busy, bus.done, bus.timeout_err, bus.mem_rd_en, bus.mem_addr, bus.cnn_in_val,
               bus.cnn_data_in, bus.decision, bus.frame_count);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.cnn_in_val !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b rd_en=%b in_val=%b, required 0 0 0",
               bus.busy, bus.mem_rd_en, bus.cnn_in_val);
    end
  endtask

  task automatic test_nominal();
    stall_mode = 1'b0;
    fill_frame(1'b1);
    start_frame(1'b0);
    wait_beats(IMG);
    vectors++;
    if (last_cyc - first_cyc != IMG - 1) begin
      miscompares++;
      $display("FAIL contiguous_beats: span %0d cycles, required %0d", last_cyc - first_cyc, IMG - 1);
    end
    finish_result(1'b1, 40, CB'(3));
  endtask

  task automatic test_timeout();
    stall_mode = 1'b0;
    fill_frame(1'b0);
    start_frame(1'b0);
    wait_beats(IMG);
    finish_result(1'b0, 0, '0);
  endtask

  task automatic test_stall();
    stall_mode = 1'b1;
    fill_frame(1'b0);
    start_frame(1'b0);
    wait_beats(IMG);
    finish_result(1'b1, int'($urandom_range(5, 50)), CB'($urandom));
    stall_mode = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    stall_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.cnn_out_val  = 1'b1;
    bus.cnn_decision = exp_dec + 1'b1;
    @(posedge clk);
    #1;
    bus.cnn_out_val = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.decision !== exp_dec || bus.frame_count !== 16'(exp_fc) || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_out_val: dec=%0d fc=%0d busy=%b, required dec=%0d fc=%0d busy=0",
               bus.decision, bus.frame_count, bus.busy, exp_dec, exp_fc);
    end
    fill_frame(1'b0);
    start_frame(1'b0);
    wait_beats(100);
    #1;
    bus.start        = 1'b1;
    bus.cnn_out_val  = 1'b1;
    bus.cnn_decision = exp_dec + 1'b1;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.cnn_out_val = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.decision !== exp_dec || bus.frame_count !== 16'(exp_fc) || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_out_val: dec=%0d fc=%0d busy=%b, required dec=%0d fc=%0d busy=1",
               bus.decision, bus.frame_count, bus.busy, exp_dec, exp_fc);
    end
    wait_beats(IMG);
    finish_result(1'b1, 40, CB'($urandom));
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.cnn_in_val !== 1'b0 || fbeat != IMG) begin
      miscompares++;
      $display("FAIL no_restart: busy=%b in_val=%b beats=%0d, required 0 0 %0d",
               bus.busy, bus.cnn_in_val, fbeat, IMG);
    end
  endtask

  task automatic test_abort();
    int d0;
    int bad;
    stall_mode = 1'b1;
    fill_frame(1'b0);
    start_frame(1'b0);
    wait_beats(300);
    #1;
    bus.abort = 1'b1;
    d0 = done_total;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.cnn_in_val !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop: in_val=%b busy=%b rd_en=%b, required 0 0 0",
               bus.cnn_in_val, bus.busy, bus.mem_rd_en);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cnn_in_val !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || done_total != d0 || bus.decision !== exp_dec || bus.frame_count !== 16'(exp_fc)) begin
      miscompares++;
      $display("FAIL abort_quiet: active=%0d done=%0d dec=%0d fc=%0d, required 0 0 %0d %0d",
               bad, done_total - d0, bus.decision, bus.frame_count, exp_dec, exp_fc);
    end
    stall_mode = 1'b0;
    start_frame(1'b1);
    wait_beats(IMG);
    finish_result(1'b1, 40, CB'($urandom));
  endtask

  task automatic test_async_reset();
    int bad;
    stall_mode = 1'b0;
    fill_frame(1'b0);
    start_frame(1'b0);
    wait_beats(200);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.timeout_err, bus.mem_rd_en, bus.mem_addr, bus.cnn_in_val,
         bus.cnn_data_in, bus.decision, bus.frame_count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b rd_en=%b addr=%0d in_val=%b data=%0d dec=%0d fc=%0d, required all 0",
               bus.busy, bus.mem_rd_en, bus.mem_addr, bus.cnn_in_val, bus.cnn_data_in,
               bus.decision, bus.frame_count);
    end
    exp_fc  = 0;
    exp_dec = '0;
    exp_to  = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en !== 1'b0 || bus.cnn_in_val !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en !== 1'b0 || bus.cnn_in_val !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_trailing: %0d active cycles, required 0", bad);
    end
    start_frame(1'b0);
    wait_beats(IMG);
    finish_result(1'b1, 40, CB'($urandom));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    frame_gen   = 0;
    stall_mode  = 1'b0;
    fbeat       = 0;
    rd_exp      = 0;
    done_total  = 0;
    cyc         = 0;
    first_cyc   = 0;
    last_cyc    = 0;
    exp_fc      = 0;
    exp_dec     = '0;
    exp_to      = 1'b0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.cnn_out_val  = 1'b0;
    bus.cnn_decision = '0;
    bus.cnn_ready    = 1'b1;
    bus.mem_rd_data  = '0;
    fork
      mem_loop();
      ready_loop();
      monitor_loop();
    join_none
    test_reset();
    test_nominal();
    test_timeout();
    test_stall();
    test_ignored_inputs();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
